// File: rtl/line_rotation_scheduler.sv
// line_rotation_scheduler
// Sequences one line-rotation scramble per active video line: fetches a random
// byte from the PRNG on each line start, maps it to a CrYCbY-aligned cut, then
// issues line buffer read addresses from the cut, wrapping at line end.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   enable_i         1 = rotate, 0 = pass-through (cut forced to 0)
//   line_start_i     1-cycle pulse, line buffer holds a new complete line
//   rand_req_o       request a random byte from the PRNG
//   rand_valid_i     rand_byte_i valid, completes handshake while rand_req_o=1
//   rand_byte_i      raw cut value
//   cut_position_o   registered cut for the current line
//   rd_addr_o        line buffer read address
//   rd_valid_o       rd_addr_o valid
//   rd_ready_i       downstream accepts rd_addr_o this cycle
//   line_done_o      1-cycle pulse after the last address of a line is accepted
//   overrun_o        1-cycle pulse, line_start_i arrived while not idle
module line_rotation_scheduler #(
    parameter int unsigned LINE_SAMPLES = 1440,
    parameter int unsigned ADDR_W       = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              line_start_i,
    output logic              rand_req_o,
    input  logic              rand_valid_i,
    input  logic [7:0]        rand_byte_i,
    output logic [ADDR_W-1:0] cut_position_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              line_done_o,
    output logic              overrun_o
);

    localparam int unsigned INTERP_W = 14;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic              rand_req_q,  rand_req_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              line_done_q, line_done_d;
    logic              overrun_q,   overrun_d;
    logic [ADDR_W-1:0] cut_q,       cut_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;

    logic [ADDR_W-1:0] interp_cut;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_next;
    logic              rd_fire;
    logic              last_fire;

    // Cut interpolator: ((byte*11)>>3 + 4)*4 at 14 bits, always a multiple of 4.
    assign interp_cut = ADDR_W'((((INTERP_W'(rand_byte_i) * INTERP_W'(11)) >> 3)
                                 + INTERP_W'(4)) << 2);

    // Read address increment with wrap at line end.
    assign addr_inc  = rd_addr_q + ADDR_W'(1);
    assign addr_next = (addr_inc == ADDR_W'(LINE_SAMPLES)) ? '0 : addr_inc;

    assign rd_fire   = rd_valid_q & rd_ready_i;
    assign last_fire = rd_fire & (cnt_q == ADDR_W'(LINE_SAMPLES - 1));

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rand_req_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            cut_q       <= '0;
            rd_addr_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rand_req_q  <= rand_req_d;
            rd_valid_q  <= rd_valid_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
            cut_q       <= cut_d;
            rd_addr_q   <= rd_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        rand_req_d  = rand_req_q;
        rd_valid_d  = rd_valid_q;
        line_done_d = 1'b0;
        overrun_d   = 1'b0;
        cut_d       = cut_q;
        rd_addr_d   = rd_addr_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
            end
            S_FETCH: begin
                if (rand_req_q && rand_valid_i) begin
                    cut_d      = interp_cut;
                    rd_addr_d  = interp_cut;
                    cnt_d      = '0;
                    rand_req_d = 1'b0;
                    rd_valid_d = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (rd_fire) begin
                    rd_addr_d = addr_next;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    if (last_fire) begin
                        rd_valid_d  = 1'b0;
                        line_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                rand_req_d = 1'b0;
                rd_valid_d = 1'b0;
            end
        endcase

        // A line start (re)launches a line from any state; only a start that
        // lands on the final handshake of the previous line is not an overrun.
        if (line_start_i) begin
            overrun_d = (state_q != S_IDLE) && !last_fire;
            cnt_d     = '0;
            if (enable_i) begin
                // A byte consumed by the FETCH branch above is discarded here.
                cut_d      = cut_q;
                rd_addr_d  = rd_addr_q;
                rand_req_d = 1'b1;
                rd_valid_d = 1'b0;
                state_d    = S_FETCH;
            end else begin
                cut_d      = '0;
                rd_addr_d  = '0;
                rand_req_d = 1'b0;
                rd_valid_d = 1'b1;
                state_d    = S_READ;
            end
        end
    end

    assign rand_req_o     = rand_req_q;
    assign rd_valid_o     = rd_valid_q;
    assign line_done_o    = line_done_q;
    assign overrun_o      = overrun_q;
    assign cut_position_o = cut_q;
    assign rd_addr_o      = rd_addr_q;

endmodule

// File: tb/tb_line_rotation_scheduler.sv
// Testbench for line_rotation_scheduler: line-level behavioural model plus a
// scoreboard of accepted read addresses, with directed line scenarios.
module tb_line_rotation_scheduler;

    localparam int LINE = 1440;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        line_start;
    logic        rand_req;
    logic        rand_valid;
    logic [7:0]  rand_byte;
    logic [10:0] cut_position;
    logic [10:0] rd_addr;
    logic        rd_valid;
    logic        rd_ready;
    logic        line_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // PRNG / downstream behaviour knobs, set by the main sequence
    int   prng_delay = 0;
    logic [7:0] prng_byte = 8'h00;
    bit   ready_rand = 1'b0;

    // Model state: phase 0 idle, 1 waiting for a byte, 2 issuing addresses
    int ph = 0;
    int m_cut = 0;
    int m_n = 0;
    bit e_done = 1'b0;
    bit e_ovr = 1'b0;

    // Scoreboard
    int q_acc[$];
    int done_line[$];
    int done_cnt = 0;
    int ovr_cnt = 0;
    int req_cycles = 0;
    bit stall_prev = 1'b0;
    int prev_addr = 0;

    line_rotation_scheduler #(.LINE_SAMPLES(1440), .ADDR_W(11)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_i       (enable),
        .line_start_i   (line_start),
        .rand_req_o     (rand_req),
        .rand_valid_i   (rand_valid),
        .rand_byte_i    (rand_byte),
        .cut_position_o (cut_position),
        .rd_addr_o      (rd_addr),
        .rd_valid_o     (rd_valid),
        .rd_ready_i     (rd_ready),
        .line_done_o    (line_done),
        .overrun_o      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int interp(int b);
        return ((b * 11) / 8 + 4) * 4;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line-level model: a line is "cut plus n accepted samples", modulo LINE.
    always @(posedge clk) begin
        int prev;
        int old_cut;
        bit fire;
        bit last;
        if (reset) begin
            ph = 0; m_cut = 0; m_n = 0; e_done = 1'b0; e_ovr = 1'b0;
        end else begin
            prev    = ph;
            old_cut = m_cut;
            e_done  = 1'b0;
            e_ovr   = 1'b0;
            fire    = (ph == 2) && rd_ready;
            last    = fire && (m_n == LINE - 1);
            if (ph == 1 && rand_valid) begin
                m_cut = interp(int'(rand_byte));
                m_n   = 0;
                ph    = 2;
            end else if (fire) begin
                m_n = m_n + 1;
                if (m_n == LINE) begin
                    ph     = 0;
                    e_done = 1'b1;
                end
            end
            if (line_start) begin
                e_ovr = (prev != 0) && !last;
                m_n   = 0;
                if (enable) begin
                    m_cut = old_cut;
                    ph    = 1;
                end else begin
                    m_cut = 0;
                    ph    = 2;
                end
            end
        end
    end

    // PRNG responder and downstream ready generator
    initial begin
        int waited;
        waited     = 0;
        rand_valid = 1'b0;
        rand_byte  = 8'h00;
        rd_ready   = 1'b0;
        forever begin
            step();
            if (rand_req) begin
                waited++;
                rand_valid = (waited > prng_delay);
                rand_byte  = prng_byte;
            end else begin
                waited     = 0;
                rand_valid = 1'b0;
            end
            rd_ready = ready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // Per-cycle compare against the model, plus address scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rand_req", int'(rand_req), int'(ph == 1));
            chk("rd_valid", int'(rd_valid), int'(ph == 2));
            chk("line_done", int'(line_done), int'(e_done));
            chk("overrun", int'(overrun), int'(e_ovr));
            if (ph != 1) begin
                chk("rd_addr", int'(rd_addr), (m_cut + m_n) % LINE);
                chk("cut_position", int'(cut_position), m_cut);
            end
            if (stall_prev && rd_valid && !overrun && !reset)
                chk("stall_hold", int'(rd_addr), prev_addr);
        end
        if (reset) q_acc.delete();
        if (overrun) begin
            ovr_cnt++;
            q_acc.delete();
        end
        if (line_done) begin
            done_cnt++;
            done_line = q_acc;
            q_acc.delete();
        end
        if (rand_req) req_cycles++;
        if (rd_valid && rd_ready) q_acc.push_back(int'(rd_addr));
        stall_prev = rd_valid && !rd_ready;
        prev_addr  = int'(rd_addr);
    end

    task automatic start_line(bit en, logic [7:0] b);
        enable     = en;
        prng_byte  = b;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_line(string name);
        int base;
        base = done_cnt;
        for (int i = 0; i < 8000 && done_cnt == base; i++) step();
        chk({name, "_done_pulses"}, done_cnt - base, 1);
    endtask

    task automatic check_line(string name, int cut);
        int bad;
        bad = 0;
        chk({name, "_len"}, done_line.size(), LINE);
        foreach (done_line[i]) if (done_line[i] != (cut + i) % LINE) bad++;
        chk({name, "_seq_errs"}, bad, 0);
        chk({name, "_first"}, (done_line.size() > 0) ? done_line[0] : -1, cut);
    endtask

    task automatic wait_acc(int n);
        for (int i = 0; i < 4000 && q_acc.size() < n; i++) step();
        chk("acc_reached", q_acc.size(), n);
    endtask

    initial begin
        int base_req;
        int base_ovr;
        reset      = 1'b1;
        enable     = 1'b0;
        line_start = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // cut from byte 0x00 is 16; one PRNG request cycle with no delay
        base_req = req_cycles;
        start_line(1'b1, 8'h00);
        wait_line("b00");
        check_line("b00", 16);
        chk("b00_cut", int'(cut_position), 16);
        chk("b00_req_cycles", req_cycles - base_req, 1);

        // reset held 3 cycles mid-line
        start_line(1'b1, 8'h10);
        repeat (100) step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_rand_req", int'(rand_req), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_cut", int'(cut_position), 0);
        chk("rst_line_done", int'(line_done), 0);
        chk("rst_overrun", int'(overrun), 0);
        base_req = req_cycles;
        repeat (10) step();
        chk("rst_no_req", req_cycles - base_req, 0);

        // extreme and mid bytes, with wrap check
        start_line(1'b1, 8'hFF);
        wait_line("bff");
        check_line("bff", 1416);
        chk("bff_cut", int'(cut_position), 1416);
        chk("bff_wrap_last", (done_line.size() > 24) ? done_line[23] : -1, 1439);
        chk("bff_wrap_zero", (done_line.size() > 24) ? done_line[24] : -1, 0);
        start_line(1'b1, 8'h80);
        wait_line("b80");
        check_line("b80", 720);
        chk("b80_cut", int'(cut_position), 720);

        // pass-through: no PRNG traffic, cut 0
        base_req = req_cycles;
        start_line(1'b0, 8'hFF);
        wait_line("pass");
        check_line("pass", 0);
        chk("pass_cut", int'(cut_position), 0);
        chk("pass_no_req", req_cycles - base_req, 0);

        // random stalls and a 5-cycle PRNG delay; byte 0x40 gives cut 368
        ready_rand = 1'b1;
        prng_delay = 5;
        base_req   = req_cycles;
        start_line(1'b1, 8'h40);
        wait_line("stall");
        check_line("stall", 368);
        chk("stall_req_cycles", req_cycles - base_req, 6);
        ready_rand = 1'b0;
        prng_delay = 0;

        // overrun at sample 700: line restarts with a new fetch
        base_ovr = ovr_cnt;
        start_line(1'b1, 8'h00);
        wait_acc(700);
        start_line(1'b1, 8'h80);
        wait_line("ovr");
        check_line("ovr", 720);
        chk("ovr_pulses", ovr_cnt - base_ovr, 1);

        // line_start coincident with the final handshake: done, no overrun
        base_ovr = ovr_cnt;
        start_line(1'b1, 8'h00);
        wait_acc(1439);
        start_line(1'b1, 8'h80);
        wait_line("coin_old");
        check_line("coin_old", 16);
        wait_line("coin_new");
        check_line("coin_new", 720);
        chk("coin_no_ovr", ovr_cnt - base_ovr, 0);

        // line_start during a completing PRNG handshake: byte discarded
        base_ovr = ovr_cnt;
        start_line(1'b1, 8'h00);
        start_line(1'b1, 8'h80);
        wait_line("disc");
        check_line("disc", 720);
        chk("disc_ovr", ovr_cnt - base_ovr, 1);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
